pipe_ctrl_hazard: RTL

//  Consumer side of the decoder's control bundle. Carries decoded control through the ID/EX, EX/MEM and MEM/WB registers.

---
 rtl/mips_ctrl_pkg.sv | 48 ++++
 rtl/pipe_ctrl_hazard_if.sv | 56 +++++
 rtl/pipe_ctrl_hazard_fwd_unit.sv | 31 +++
 rtl/pipe_ctrl_hazard.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared control-bundle types and encodings for the decoder-to-pipeline control path.
// Stage structs shrink as fields are consumed so each stage only carries what it still needs.
package mips_ctrl_pkg;

    typedef struct packed {
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
        logic [1:0] alu_op;
    } ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
    } ex_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
    } mem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

endpackage

// File: rtl/pipe_ctrl_hazard_if.sv
// Control bundle between the ID decoder/datapath and the pipeline control unit.
// master = decoder/datapath side, slave = pipe_ctrl_hazard.
interface pipe_ctrl_hazard_if #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic             id_reg_dst;
    logic             id_reg_write;
    logic             id_alu_src;
    logic             id_mem_read;
    logic             id_mem_write;
    logic             id_mem_to_reg;
    logic             id_branch;
    logic             id_jump;
    logic [1:0]       id_alu_op;
    logic [RA_W-1:0]  id_rs;
    logic [RA_W-1:0]  id_rt;
    logic [RA_W-1:0]  id_rd;
    logic             ex_branch_taken;

    logic             stall;
    logic             flush_ifid;
    logic             ex_alu_src;
    logic             ex_mem_read;
    logic             ex_mem_write;
    logic             ex_branch;
    logic [1:0]       ex_alu_op;
    logic [RA_W-1:0]  ex_dest;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             mem_mem_read;
    logic             mem_mem_write;
    logic             wb_reg_write;
    logic             wb_mem_to_reg;
    logic [RA_W-1:0]  wb_dest;
    logic [CNT_W-1:0] bubble_cnt;

    modport master (
        output id_valid, id_reg_dst, id_reg_write, id_alu_src, id_mem_read,
               id_mem_write, id_mem_to_reg, id_branch, id_jump, id_alu_op,
               id_rs, id_rt, id_rd, ex_branch_taken,
        input  stall, flush_ifid, ex_alu_src, ex_mem_read, ex_mem_write,
               ex_branch, ex_alu_op, ex_dest, fwd_a, fwd_b, mem_mem_read,
               mem_mem_write, wb_reg_write, wb_mem_to_reg, wb_dest, bubble_cnt
    );

    modport slave (
        input  id_valid, id_reg_dst, id_reg_write, id_alu_src, id_mem_read,
               id_mem_write, id_mem_to_reg, id_branch, id_jump, id_alu_op,
               id_rs, id_rt, id_rd, ex_branch_taken,
        output stall, flush_ifid, ex_alu_src, ex_mem_read, ex_mem_write,
               ex_branch, ex_alu_op, ex_dest, fwd_a, fwd_b, mem_mem_read,
               mem_mem_write, wb_reg_write, wb_mem_to_reg, wb_dest, bubble_cnt
    );
endinterface

// File: rtl/pipe_ctrl_hazard_fwd_unit.sv
// EX-stage forwarding select for a single source operand.
// The younger result in MEM takes precedence over WB; register 0 is never forwarded.
module fwd_unit
    import mips_ctrl_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] src,
    input  logic            mem_valid,
    input  logic            mem_reg_write,
    input  logic [RA_W-1:0] mem_dest,
    input  logic            wb_valid,
    input  logic            wb_reg_write,
    input  logic [RA_W-1:0] wb_dest,
    output logic [1:0]      sel
);
    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_valid & mem_reg_write & (mem_dest != '0) & (mem_dest == src);
    assign wb_hit  = wb_valid  & wb_reg_write  & (wb_dest  != '0) & (wb_dest  == src);

    always_comb begin
        sel = FWD_REG;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end
endmodule

// File: rtl/pipe_ctrl_hazard.sv
// ID/EX, EX/MEM, MEM/WB control registers with load-use stall, branch/jump squash,
// EX forwarding selects and a saturating count of inserted bubbles.
module pipe_ctrl_hazard
    import mips_ctrl_pkg::*;
#(
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_ctrl_hazard_if.slave    bus
);
    ctrl_t            id_ctrl;
    logic             uses_rt;
    logic             load_use;
    logic             br;
    logic             jmp;
    logic             squash;
    logic             ex_load;

    logic             ex_valid_reg,  mem_valid_reg, wb_valid_reg;
    ex_ctrl_t         ex_ctrl_reg,   ex_ctrl_next;
    mem_ctrl_t        mem_ctrl_reg;
    wb_ctrl_t         wb_ctrl_reg;
    logic [RA_W-1:0]  ex_dest_reg,   ex_dest_next;
    logic [RA_W-1:0]  ex_rs_reg,     ex_rs_next;
    logic [RA_W-1:0]  ex_rt_reg,     ex_rt_next;
    logic [RA_W-1:0]  mem_dest_reg,  wb_dest_reg;
    logic [CNT_W-1:0] bubble_cnt_reg, bubble_cnt_next;

    logic [RA_W-1:0]  fwd_src [2];
    logic [1:0]       fwd_sel [2];

    assign id_ctrl = '{reg_dst:    bus.id_reg_dst,   reg_write: bus.id_reg_write,
                       alu_src:    bus.id_alu_src,   mem_read:  bus.id_mem_read,
                       mem_write:  bus.id_mem_write, mem_to_reg: bus.id_mem_to_reg,
                       branch:     bus.id_branch,    jump:      bus.id_jump,
                       alu_op:     bus.id_alu_op};

    // Hazard detection; branch resolution in EX outranks everything in ID.
    assign uses_rt  = ~id_ctrl.alu_src | id_ctrl.mem_write | id_ctrl.branch;
    assign load_use = ex_valid_reg & ex_ctrl_reg.mem_read & (ex_dest_reg != '0)
                    & ((ex_dest_reg == bus.id_rs) | (uses_rt & (ex_dest_reg == bus.id_rt)))
                    & bus.id_valid;
    assign br       = ex_valid_reg & ex_ctrl_reg.branch & bus.ex_branch_taken;
    assign jmp      = bus.id_valid & id_ctrl.jump;
    assign squash   = br | load_use | jmp;
    assign ex_load  = bus.id_valid & ~squash;

    assign bus.stall      = load_use & ~br;
    assign bus.flush_ifid = br | (jmp & ~load_use);

    always_comb begin
        ex_ctrl_next = '0;
        ex_dest_next = '0;
        ex_rs_next   = '0;
        ex_rt_next   = '0;
        if (ex_load) begin
            ex_ctrl_next = '{reg_write: id_ctrl.reg_write, mem_to_reg: id_ctrl.mem_to_reg,
                             alu_src:   id_ctrl.alu_src,   mem_read:   id_ctrl.mem_read,
                             mem_write: id_ctrl.mem_write, branch:     id_ctrl.branch,
                             alu_op:    id_ctrl.alu_op};
            ex_dest_next = id_ctrl.reg_dst ? bus.id_rd : bus.id_rt;
            ex_rs_next   = bus.id_rs;
            ex_rt_next   = bus.id_rt;
        end
    end

    // Idle ID cycles are not bubbles we caused, so they are not counted.
    always_comb begin
        bubble_cnt_next = bubble_cnt_reg;
        if (bus.id_valid & squash & (bubble_cnt_reg != {CNT_W{1'b1}})) begin
            bubble_cnt_next = bubble_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_reg   <= 1'b0;
            ex_ctrl_reg    <= '0;
            ex_dest_reg    <= '0;
            ex_rs_reg      <= '0;
            ex_rt_reg      <= '0;
            mem_valid_reg  <= 1'b0;
            mem_ctrl_reg   <= '0;
            mem_dest_reg   <= '0;
            wb_valid_reg   <= 1'b0;
            wb_ctrl_reg    <= '0;
            wb_dest_reg    <= '0;
            bubble_cnt_reg <= '0;
        end else begin
            ex_valid_reg   <= ex_load;
            ex_ctrl_reg    <= ex_ctrl_next;
            ex_dest_reg    <= ex_dest_next;
            ex_rs_reg      <= ex_rs_next;
            ex_rt_reg      <= ex_rt_next;
            mem_valid_reg  <= ex_valid_reg;
            mem_ctrl_reg   <= '{reg_write: ex_ctrl_reg.reg_write, mem_to_reg: ex_ctrl_reg.mem_to_reg,
                                mem_read:  ex_ctrl_reg.mem_read,  mem_write:  ex_ctrl_reg.mem_write};
            mem_dest_reg   <= ex_dest_reg;
            wb_valid_reg   <= mem_valid_reg;
            wb_ctrl_reg    <= '{reg_write: mem_ctrl_reg.reg_write, mem_to_reg: mem_ctrl_reg.mem_to_reg};
            wb_dest_reg    <= mem_dest_reg;
            bubble_cnt_reg <= bubble_cnt_next;
        end
    end

    assign fwd_src[0] = ex_rs_reg;
    assign fwd_src[1] = ex_rt_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_unit #(.RA_W(RA_W)) u_fwd (
                .src           (fwd_src[gi]),
                .mem_valid     (mem_valid_reg),
                .mem_reg_write (mem_ctrl_reg.reg_write),
                .mem_dest      (mem_dest_reg),
                .wb_valid      (wb_valid_reg),
                .wb_reg_write  (wb_ctrl_reg.reg_write),
                .wb_dest       (wb_dest_reg),
                .sel           (fwd_sel[gi])
            );
        end
    endgenerate

    assign bus.fwd_a         = fwd_sel[0];
    assign bus.fwd_b         = fwd_sel[1];
    assign bus.ex_alu_src    = ex_ctrl_reg.alu_src;
    assign bus.ex_mem_read   = ex_ctrl_reg.mem_read;
    assign bus.ex_mem_write  = ex_ctrl_reg.mem_write;
    assign bus.ex_branch     = ex_ctrl_reg.branch;
    assign bus.ex_alu_op     = ex_ctrl_reg.alu_op;
    assign bus.ex_dest       = ex_dest_reg;
    assign bus.mem_mem_read  = mem_ctrl_reg.mem_read;
    assign bus.mem_mem_write = mem_ctrl_reg.mem_write;
    assign bus.wb_reg_write  = wb_ctrl_reg.reg_write;
    assign bus.wb_mem_to_reg = wb_ctrl_reg.mem_to_reg;
    assign bus.wb_dest       = wb_dest_reg;
    assign bus.bubble_cnt    = bubble_cnt_reg;
endmodule
